// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : genius_pkg
//  Description : Shared VGA timing constants, default counter width and the
//                profiler state encoding for the Genius pixel path.
//  Revision    : 1.0  initial release
// ============================================================================
package genius_pkg;

  // 640x480 @ 60 Hz timing on the 25 MHz pixel clock
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  // 19 bits hold one whole frame of clocks (800*525 = 420000)
  localparam int DEFAULT_CNT_W = 19;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    COUNT     = 2'd1,
    DRAIN     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_channel_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_channel_counter
//  Description : One profiler channel: saturating live counter, sticky
//                saturation flag and the per-frame snapshot register.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_channel_counter
  import genius_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,        // qualified increment for this clock
  input  logic             clear_i,      // frame boundary: restart live count
  input  logic             snap_i,       // frame boundary: capture live count
  output logic [CNT_W-1:0] snap_count_o,
  output logic             snap_sat_o
);

  localparam logic [CNT_W-1:0] MAX_COUNT = '1;

  logic [CNT_W-1:0] live_q, live_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             snap_sat_q, snap_sat_d;

  // Next-state: the boundary clock itself belongs to the new frame, so the
  // live counter restarts at that clock's increment rather than at zero.
  always_comb begin
    live_d     = live_q;
    sat_d      = sat_q;
    snap_d     = snap_q;
    snap_sat_d = snap_sat_q;
    if (snap_i) begin
      snap_d     = live_q;
      snap_sat_d = sat_q;
    end
    if (clear_i) begin
      live_d = CNT_W'(inc_i);
      sat_d  = 1'b0;
    end else if (inc_i) begin
      if (live_q == MAX_COUNT) begin
        sat_d = 1'b1;
      end else begin
        live_d = live_q + CNT_W'(1);
      end
    end
  end

  // Channel registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q     <= '0;
      sat_q      <= 1'b0;
      snap_q     <= '0;
      snap_sat_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      sat_q      <= sat_d;
      snap_q     <= snap_d;
      snap_sat_q <= snap_sat_d;
    end
  end

  assign snap_count_o = snap_q;
  assign snap_sat_o   = snap_sat_q;

endmodule
`default_nettype wire

// File: rtl/sprite_pixel_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pixel_profiler
//  Description : Per-frame, per-channel sprite-enable pixel counter. Snapshots
//                all channels at each VS falling edge and streams them out
//                over valid/ready, flagging frames dropped while draining.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_pixel_profiler
  import genius_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLOCK_25,
  input  logic             RESET,
  input  logic [N_CH-1:0]  SPRITES_EN,
  input  logic             VGA_BLANK_N,
  input  logic             VGA_VS,
  input  logic             COUNT_MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [3:0]       OUT_CH,
  output logic [CNT_W-1:0] OUT_COUNT,
  output logic             OUT_SAT,
  output logic             OUT_LAST,
  output logic [7:0]       FRAME_ID,
  output logic             FRAME_DROP
);

  localparam logic [3:0] LAST_CH = 4'(N_CH - 1);

  state_t     state_q, state_d;
  logic       vs_prev_q;
  logic       mode_q, mode_d;
  logic [3:0] ch_q, ch_d;
  logic       valid_q, valid_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] frame_id_q, frame_id_d;
  logic       drop_q, drop_d;

  logic             fb;
  logic             qual;
  logic             count_ok;
  logic             snap_load;
  logic             beat_acc;
  logic             last_ch;
  logic [N_CH-1:0]  inc;
  logic [CNT_W-1:0] snap_count [N_CH];
  logic [N_CH-1:0]  snap_sat;
  logic [CNT_W-1:0] sel_count;
  logic             sel_sat;

  // Frame boundary is the falling edge of the active-low VS
  assign fb        = ~VGA_VS & vs_prev_q;
  // The boundary clock already counts under the newly latched mode
  assign qual      = mode_d | VGA_BLANK_N;
  assign count_ok  = (state_q != WAIT_SYNC) | fb;
  assign snap_load = fb & (state_q == COUNT);
  assign beat_acc  = valid_q & OUT_READY;
  assign last_ch   = (ch_q == LAST_CH);
  assign inc       = SPRITES_EN & {N_CH{qual & count_ok}};

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    sprite_channel_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i        (CLOCK_25),
      .rst_i        (RESET),
      .inc_i        (inc[gi]),
      .clear_i      (fb),
      .snap_i       (snap_load),
      .snap_count_o (snap_count[gi]),
      .snap_sat_o   (snap_sat[gi])
    );
  end

  // Next state, drain sequencing and frame numbering
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ch_d        = ch_q;
    valid_d     = valid_q;
    frame_cnt_d = frame_cnt_q;
    frame_id_d  = frame_id_q;
    drop_d      = 1'b0;
    if (fb) begin
      mode_d = COUNT_MODE;
    end
    case (state_q)
      WAIT_SYNC: begin
        if (fb) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (fb) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          frame_id_d  = frame_cnt_q + 8'd1;
          ch_d        = 4'd0;
          valid_d     = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Overrun: snapshot is kept, only the frame number moves on
        if (fb) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          drop_d      = 1'b1;
        end
        if (beat_acc) begin
          if (last_ch) begin
            ch_d    = 4'd0;
            valid_d = 1'b0;
            state_d = COUNT;
          end else begin
            ch_d = ch_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase
  end

  // Control registers with synchronous reset; VS history resets high
  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      state_q     <= WAIT_SYNC;
      vs_prev_q   <= 1'b1;
      mode_q      <= 1'b0;
      ch_q        <= 4'd0;
      valid_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
      frame_id_q  <= 8'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_prev_q   <= VGA_VS;
      mode_q      <= mode_d;
      ch_q        <= ch_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      frame_id_q  <= frame_id_d;
      drop_q      <= drop_d;
    end
  end

  // Drain multiplexer selecting the snapshot of the current beat's channel
  always_comb begin
    sel_count = '0;
    sel_sat   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == 4'(i)) begin
        sel_count = snap_count[i];
        sel_sat   = snap_sat[i];
      end
    end
  end

  assign OUT_VALID  = valid_q;
  assign OUT_CH     = valid_q ? ch_q : 4'd0;
  assign OUT_COUNT  = valid_q ? sel_count : '0;
  assign OUT_SAT    = valid_q & sel_sat;
  assign OUT_LAST   = valid_q & last_ch;
  assign FRAME_ID   = frame_id_q;
  assign FRAME_DROP = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_pixel_profiler
//  Description : Directed self-checking bench for sprite_pixel_profiler using
//                short synthetic frames (FB, 8 blank, K active, 2 blank).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_pixel_profiler;

  localparam int N_CH  = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             bn;
  logic             vs;
  logic             mode;
  logic             ready;
  logic             out_valid;
  logic [3:0]       out_ch;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             out_last;
  logic [7:0]       frame_id;
  logic             frame_drop;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_cnt [N_CH];
  logic [7:0] exp_sat;
  logic [7:0] exp_fid;

  sprite_pixel_profiler #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .CLOCK_25    (clk),
    .RESET       (rst),
    .SPRITES_EN  (en),
    .VGA_BLANK_N (bn),
    .VGA_VS      (vs),
    .COUNT_MODE  (mode),
    .OUT_VALID   (out_valid),
    .OUT_READY   (ready),
    .OUT_CH      (out_ch),
    .OUT_COUNT   (out_count),
    .OUT_SAT     (out_sat),
    .OUT_LAST    (out_last),
    .FRAME_ID    (frame_id),
    .FRAME_DROP  (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a few thousand clocks at most
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, then settle 1 time unit after the edge
  task automatic step(input logic b, input logic v, input logic [7:0] e);
    bn = b;
    vs = v;
    en = e;
    @(posedge clk);
    #1;
  endtask

  // One frame-boundary clock (VS low) with the given mode and enables
  task automatic fb(input logic md, input logic [7:0] e);
    mode = md;
    step(1'b0, 1'b0, e);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N_CH; i++) exp_cnt[i] = v;
  endtask

  task automatic check_beat(input int c);
    chk($sformatf("beat%0d_valid", c), 32'(out_valid), 32'd1);
    chk($sformatf("beat%0d_ch", c),    32'(out_ch),    32'(c));
    chk($sformatf("beat%0d_count", c), 32'(out_count), 32'(exp_cnt[c]));
    chk($sformatf("beat%0d_sat", c),   32'(out_sat),   32'(exp_sat[c]));
    chk($sformatf("beat%0d_last", c),  32'(out_last),  (c == N_CH - 1) ? 32'd1 : 32'd0);
    chk($sformatf("beat%0d_fid", c),   32'(frame_id),  32'(exp_fid));
  endtask

  // Accept beats start..N_CH-1 back to back during blanking
  task automatic drain(input int start, input logic [7:0] e);
    ready = 1'b1;
    for (int c = start; c < N_CH; c++) begin
      check_beat(c);
      step(1'b0, 1'b1, e);
    end
    chk("drain_done_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b1; bn = 1'b0; en = '0; mode = 1'b0; ready = 1'b0;
    fill(8'd0); exp_sat = 8'h00; exp_fid = 8'd0;
    repeat (3) step(1'b0, 1'b1, 8'h00);

    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_ch",    32'(out_ch),     32'd0);
    chk("rst_count", 32'(out_count),  32'd0);
    chk("rst_sat",   32'(out_sat),    32'd0);
    chk("rst_last",  32'(out_last),   32'd0);
    chk("rst_fid",   32'(frame_id),   32'd0);
    chk("rst_drop",  32'(frame_drop), 32'd0);
    rst = 1'b0;

    // Partial frame before the first sync produces nothing
    repeat (20) step(1'b1, 1'b1, 8'hFF);
    chk("presync_valid", 32'(out_valid), 32'd0);

    // Frame 1, gated: ch0 high all frame, 40 active clocks -> 40
    fb(1'b0, 8'h01);
    chk("fb1_no_output", 32'(out_valid), 32'd0);
    repeat (8) step(1'b0, 1'b1, 8'h01);
    chk("fb1_idle_valid", 32'(out_valid), 32'd0);
    repeat (40) step(1'b1, 1'b1, 8'h01);
    repeat (2) step(1'b0, 1'b1, 8'h01);

    // Frame 2, ungated, all channels: 1 + 8 + 40 + 2 = 51
    fill(8'd0); exp_cnt[0] = 8'd40; exp_sat = 8'h00; exp_fid = 8'd1;
    fb(1'b1, 8'hFF);
    drain(0, 8'hFF);
    repeat (40) step(1'b1, 1'b1, 8'hFF);
    repeat (2) step(1'b0, 1'b1, 8'hFF);

    // Frame 3: mode input drops to 0 mid-frame, frame still counts ungated
    fill(8'd51); exp_fid = 8'd2;
    fb(1'b1, 8'hFF);
    mode = 1'b0;
    drain(0, 8'hFF);
    repeat (40) step(1'b1, 1'b1, 8'hFF);
    repeat (2) step(1'b0, 1'b1, 8'hFF);

    // Frame 4, gated: ch3 high for 300 active clocks -> saturates at 255
    fill(8'd51); exp_fid = 8'd3;
    fb(1'b0, 8'h00);
    drain(0, 8'h00);
    repeat (300) step(1'b1, 1'b1, 8'h08);
    repeat (2) step(1'b0, 1'b1, 8'h00);

    // Frame 5, gated: ch3 active for 10; all enables high in blanking
    fill(8'd0); exp_cnt[3] = 8'd255; exp_sat = 8'h08; exp_fid = 8'd4;
    fb(1'b0, 8'hFF);
    drain(0, 8'hFF);
    repeat (10) step(1'b1, 1'b1, 8'h08);
    repeat (2) step(1'b0, 1'b1, 8'hFF);

    // Frame 6: stall on beat 3 across the next boundary
    fill(8'd0); exp_cnt[3] = 8'd10; exp_sat = 8'h00; exp_fid = 8'd5;
    fb(1'b0, 8'h00);
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_beat(c);
      step(1'b0, 1'b1, 8'h00);
    end
    ready = 1'b0;
    check_beat(3);
    repeat (30) step(1'b1, 1'b1, 8'hFF);
    repeat (2) step(1'b0, 1'b1, 8'h00);
    check_beat(3);
    chk("no_drop_before_fb", 32'(frame_drop), 32'd0);

    // Overrunning boundary: one-cycle drop pulse, held beat unchanged
    fb(1'b0, 8'h00);
    chk("drop_pulse", 32'(frame_drop), 32'd1);
    check_beat(3);
    step(1'b0, 1'b1, 8'h00);
    chk("drop_once", 32'(frame_drop), 32'd0);
    check_beat(3);
    drain(3, 8'h00);
    repeat (20) step(1'b1, 1'b1, 8'h81);
    repeat (2) step(1'b0, 1'b1, 8'h00);

    // Frame 7 snapshot: FRAME_ID skips 6
    fill(8'd0); exp_cnt[0] = 8'd20; exp_cnt[7] = 8'd20; exp_sat = 8'h00; exp_fid = 8'd7;
    fb(1'b0, 8'h00);
    ready = 1'b1;
    check_beat(0);
    step(1'b0, 1'b1, 8'h00);
    check_beat(1);
    step(1'b0, 1'b1, 8'h00);

    // Reset mid-drain
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk("rst_drain_valid", 32'(out_valid), 32'd0);
    chk("rst_drain_fid",   32'(frame_id),  32'd0);
    rst = 1'b0;
    repeat (5) step(1'b0, 1'b1, 8'h00);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // First boundary after reset: no output
    fb(1'b0, 8'hFF);
    chk("post_rst_fb1_valid", 32'(out_valid), 32'd0);
    repeat (8) step(1'b0, 1'b1, 8'hFF);
    chk("post_rst_idle_valid", 32'(out_valid), 32'd0);
    repeat (5) step(1'b1, 1'b1, 8'hFF);
    repeat (2) step(1'b0, 1'b1, 8'hFF);

    // Second boundary after reset: valid snapshot, gated count of 5
    fill(8'd5); exp_sat = 8'h00; exp_fid = 8'd1;
    fb(1'b0, 8'h00);
    drain(0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
